if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 16-bit pipelined ThinPad CPU, sitting directly upstream of the decode stage. It owns the program counter and issues word fetches to the instruction-memory port over a req/ack handshake. It absorbs decode-stage stalls with a one-entry skid buffer, applies redirects from the decoder's jump/branch resolution, and drives the IF/ID pipeline register that decode consumes.

## Interface
- `RESET_PC`, 16'h0000: first fetch address after reset.
- `NOP_INSTR`, 16'h0800: encoding placed in IF/ID when a slot is squashed.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: from the hazard unit; hold IF/ID contents this cycle.
- `branch_taken` in 1: one-cycle redirect pulse from decode.
- `branch_target` in 16: redirect word address, valid with `branch_taken`.
- `mem_req` out 1: fetch request to instruction memory.
- `mem_addr` out 16: word address; stable while `mem_req`=1 and not acked.
- `mem_rdata` in 16: fetched word, valid when `mem_ack`=1.
- `mem_ack` in 1: fetch completes this cycle; may coincide with the first `mem_req` cycle.
- `if_instr` out 16: IF/ID instruction, feeds decode `instr`.
- `if_pc` out 16: address of `if_instr`.
- `if_pc_plus1` out 16: `if_pc`+1, for link and PC-relative targets.
- `if_valid` out 1: IF/ID holds a real instruction.

## Operation
- Word-addressed memory: next sequential PC = PC+1, modulo 2^16, so 16'hFFFF wraps to 16'h0000.
- Registers: `pc` (next fetch address), `kill` (discard the in-flight fetch), skid buffer (`buf_instr`, `buf_pc`), IF/ID (`if_instr`, `if_pc`, `if_valid`).

FSM states:
- REQ:
  - `mem_req`=1 and `mem_addr`=`pc`.
  - On ack, not discarded, `stall`=0: IF/ID <= {`mem_rdata`, `pc`, 1}; `pc`<=`pc`+1; stay in REQ.
  - On ack, not discarded, `stall`=1: buffer <= {`mem_rdata`, `pc`}; `pc`<=`pc`+1; go to HOLD.
  - On ack, discarded (`kill`=1): drop the data and clear `kill`; stay in REQ.
- HOLD:
  - `mem_req`=0.
  - When `stall`=0: IF/ID <= {buffer, 1}; go to REQ.
- Stall with no ack, in either state: IF/ID unchanged.
- Redirect (`branch_taken`=1): `pc`<=`branch_target` with priority over the increment.
  - The fetch in flight at redirect time, whether acked in that cycle, acked later, or sitting in the buffer, is the delay-slot instruction. Its fate is set by the macro in Configuration.
  - A not-yet-acked fetch keeps its address until ack, because `mem_addr` may not change mid-request.
- Interface contract: `branch_taken` and `stall` are never both 1. The bench asserts this.
- Priority: `rst` > redirect > stall > sequential.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=`RESET_PC`, `pc`=`RESET_PC`, `if_instr`=`NOP_INSTR`, `if_pc`=0, `if_pc_plus1`=1, `if_valid`=0, `kill`=0, state=REQ.
- The first request rises in the cycle after `rst` falls.
- Zero-wait memory (ack in the request cycle): one instruction per cycle; IF/ID updates on the ack edge.
- N wait cycles: IF/ID updates N+1 cycles after `mem_req` rises.
- `rst` mid-fetch: the request is abandoned immediately; a late ack for it after reset is a memory-side error and is not tolerated.
- Leaving HOLD costs one bubble-free cycle. The next request issues in the cycle IF/ID loads from the buffer.

## Configuration
- `IF_DELAY_SLOT_EN` defined (MIPS16 semantics):
  - The delay-slot instruction is delivered to IF/ID normally.
  - `kill` is never set.
  - The first post-redirect fetch is at `branch_target`.
- `IF_DELAY_SLOT_EN` undefined:
  - The delay-slot instruction is squashed: IF/ID <= {`NOP_INSTR`, 0 valid} in its place.
  - An unacked fetch sets `kill`; a buffered one is discarded on HOLD exit.
  - The first valid post-redirect instruction comes from `branch_target`.

## Structure
- Shared CPU constants header/package: `RESET_PC` default, `NOP_INSTR`, IF FSM state encodings (REQ, HOLD). Decode and the hazard unit share the NOP definition.
- One natural sub-module: `if_skid_buf`, the one-entry instruction/PC holding register with load/unload controls. PC and FSM logic stay in `if_stage`.

## Test plan
- Reset then zero-wait memory returning `mem_rdata`=addr+16'h1000:
  - `mem_addr` sequence is 0, 1, 2.
  - `if_instr` sequence is 16'h1000, 16'h1001, 16'h1002 on consecutive cycles.
  - `if_valid` rises on the first ack edge.
- Two-cycle-wait memory:
  - Each `mem_addr` is held for 3 cycles.
  - One instruction is delivered per 3 cycles.
  - `mem_addr` is stable throughout each wait.
- `stall` high for 3 cycles during an ack at addr 5:
  - IF/ID is frozen.
  - State goes to HOLD; `mem_req`=0.
  - On release, `if_pc`=5, then the next request is at addr 6.
- Redirect to 16'h0040 while the fetch of addr 9 is unacked:
  - With the macro: `if_pc` sequence 9, 16'h0040.
  - Without the macro: one `if_valid`=0 slot carrying `if_instr`=16'h0800, then `if_pc`=16'h0040.
- `pc`=16'hFFFF sequential fetch:
  - The next `mem_addr` is 16'h0000.
  - `if_pc_plus1` for 16'hFFFF is 16'h0000.
- `rst` asserted mid-wait with `stall` high:
  - Next cycle: all outputs at reset values.
  - Fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared ThinPad CPU constants: reset vector, the NOP encoding used by fetch,
// decode and the hazard unit, and the instruction-fetch FSM state encoding.
package if_stage_pkg;

    localparam int DATA_W = 16;

    localparam logic [DATA_W-1:0] RESET_PC_DEFAULT = 16'h0000;
    localparam logic [DATA_W-1:0] NOP_INSTR        = 16'h0800;

    typedef enum logic {
        REQ  = 1'b0,
        HOLD = 1'b1
    } ifState_e;

    // Word-addressed sequential step; wraps 16'hFFFF to 16'h0000.
    function automatic logic [DATA_W-1:0] pcInc(input logic [DATA_W-1:0] pc);
        return pc + DATA_W'(1);
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry instruction/PC holding register that parks a fetched word while
// decode is stalled; it is unloaded by the fetch stage when the stall clears.
module if_skid_buf
    import if_stage_pkg::*;
(
    input  logic              clk,
    input  logic              load,
    input  logic [DATA_W-1:0] instrIn,
    input  logic [DATA_W-1:0] pcIn,
    output logic [DATA_W-1:0] bufInstr,
    output logic [DATA_W-1:0] bufPc
);

    always_ff @(posedge clk) begin
        if (load) begin
            bufInstr <= instrIn;
            bufPc    <= pcIn;
        end
    end

endmodule

// File: rtl/if_stage.sv
// ThinPad instruction-fetch stage: PC, req/ack fetch FSM, skid buffer, IF/ID.
// Define IF_DELAY_SLOT_EN to deliver the branch delay slot instead of squashing it.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [DATA_W-1:0] branch_target,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] if_instr,
    output logic [DATA_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_pc_plus1,
    output logic              if_valid
);

`ifdef IF_DELAY_SLOT_EN
    localparam bit SQUASH_SLOT = 1'b0;
`else
    localparam bit SQUASH_SLOT = 1'b1;
`endif

    ifState_e          state;
    logic [DATA_W-1:0] pc;
    logic              kill;
    logic [DATA_W-1:0] bufInstr;
    logic [DATA_W-1:0] bufPc;
    logic [DATA_W-1:0] nextAddr;
    logic              ackLive;
    logic              slotDrop;
    logic              bufLoad;
    logic              launch;
    logic              loadFetch;
    logic              loadBuf;
    logic              loadBubble;

    // pc always holds the address of the fetch that follows the one in flight,
    // so a redirect can overwrite it without disturbing mem_addr mid-request.
    assign nextAddr    = branch_taken ? branch_target : pc;
    assign ackLive     = (state == REQ) && mem_req && mem_ack;
    assign slotDrop    = kill || (SQUASH_SLOT && branch_taken);
    assign bufLoad     = ackLive && !slotDrop && stall;
    assign if_pc_plus1 = pcInc(if_pc);

    always_comb begin
        launch     = 1'b0;
        loadFetch  = 1'b0;
        loadBuf    = 1'b0;
        loadBubble = 1'b0;
        if (state == REQ) begin
            if (!mem_req) begin
                launch     = 1'b1;
                loadBubble = !stall;
            end else if (mem_ack) begin
                if (slotDrop) begin
                    launch     = 1'b1;
                    loadBubble = !stall;
                end else if (!stall) begin
                    launch    = 1'b1;
                    loadFetch = 1'b1;
                end
            end else begin
                loadBubble = !stall;
            end
        end else if (!stall) begin
            launch     = 1'b1;
            loadBuf    = !slotDrop;
            loadBubble = slotDrop;
        end
    end

    if_skid_buf u_skidBuf (
        .clk      (clk),
        .load     (bufLoad),
        .instrIn  (mem_rdata),
        .pcIn     (mem_addr),
        .bufInstr (bufInstr),
        .bufPc    (bufPc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= REQ;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            pc       <= RESET_PC;
            kill     <= 1'b0;
            if_instr <= NOP_INSTR;
            if_pc    <= '0;
            if_valid <= 1'b0;
        end else begin
            if (launch) begin
                state    <= REQ;
                mem_req  <= 1'b1;
                mem_addr <= nextAddr;
                pc       <= pcInc(nextAddr);
            end else begin
                if (branch_taken) begin
                    pc <= branch_target;
                end
                if (bufLoad) begin
                    state   <= HOLD;
                    mem_req <= 1'b0;
                end
            end

            // A redirect while the request is still waiting marks that fetch as the delay slot.
            if (ackLive) begin
                kill <= 1'b0;
            end else if ((state == REQ) && mem_req && branch_taken) begin
                kill <= SQUASH_SLOT;
            end

            // IF/ID register
            if (loadFetch) begin
                if_instr <= mem_rdata;
                if_pc    <= mem_addr;
                if_valid <= 1'b1;
            end else if (loadBuf) begin
                if_instr <= bufInstr;
                if_pc    <= bufPc;
                if_valid <= 1'b1;
            end else if (loadBubble) begin
                if_instr <= NOP_INSTR;
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed test-plan scenarios with literal
// expectations, then randomized stall/redirect/wait traffic against a fetch model.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus1;
    logic        if_valid;

    always #5 clk = ~clk;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_pc_plus1   (if_pc_plus1),
        .if_valid      (if_valid)
    );

`ifdef IF_DELAY_SLOT_EN
    localparam bit SQUASH = 1'b0;
`else
    localparam bit SQUASH = 1'b1;
`endif

    always @(posedge clk) begin
        assert (!(branch_taken && stall)) else $error("contract broken: branch_taken with stall");
    end

    int checks = 0;
    int errors = 0;
    bit checkOn = 1'b0;
    int waitMode = 0;

    // Fetch model: one outstanding request, an optional parked word, and what decode sees.
    bit          mReq;
    logic [15:0] mAddr;
    logic [15:0] mNext;
    int          mWait;
    bit          mDrop;
    bit          mParked;
    logic [15:0] parkInstr;
    logic [15:0] parkPc;
    logic [15:0] mInstr;
    logic [15:0] mPc;
    bit          mValid;

    function automatic logic [15:0] memWord(input logic [15:0] a);
        return a + 16'h1000;
    endfunction

    function automatic int pickWait();
        if (waitMode < 0) return int'($urandom_range(0, 3));
        return waitMode;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mReq    = 1'b0;
        mAddr   = 16'h0000;
        mNext   = 16'h0000;
        mWait   = 0;
        mDrop   = 1'b0;
        mParked = 1'b0;
        mInstr  = 16'h0800;
        mPc     = 16'h0000;
        mValid  = 1'b0;
    endtask

    task automatic modelStep(input bit r, input bit s, input bit b, input logic [15:0] t, input bit ack);
        logic [15:0] dest;
        bit          start;
        bit          bubble;
        if (r) begin
            modelReset();
        end else begin
            dest   = b ? t : mNext;
            start  = 1'b0;
            bubble = 1'b0;
            if (mParked) begin
                if (!s) begin
                    mParked = 1'b0;
                    start   = 1'b1;
                    if (SQUASH && b) begin
                        bubble = 1'b1;
                    end else begin
                        mInstr = parkInstr;
                        mPc    = parkPc;
                        mValid = 1'b1;
                    end
                end
            end else if (!mReq) begin
                start  = 1'b1;
                bubble = !s;
            end else if (ack) begin
                if (mDrop || (SQUASH && b)) begin
                    mDrop  = 1'b0;
                    start  = 1'b1;
                    bubble = !s;
                end else if (s) begin
                    mParked   = 1'b1;
                    parkInstr = memWord(mAddr);
                    parkPc    = mAddr;
                    mReq      = 1'b0;
                end else begin
                    mInstr = memWord(mAddr);
                    mPc    = mAddr;
                    mValid = 1'b1;
                    start  = 1'b1;
                end
            end else begin
                mWait--;
                if (b) begin
                    mNext = t;
                    if (SQUASH) mDrop = 1'b1;
                end
                bubble = !s;
            end
            if (bubble) begin
                mInstr = 16'h0800;
                mValid = 1'b0;
            end
            if (start) begin
                mReq  = 1'b1;
                mAddr = dest;
                mNext = dest + 16'd1;
                mWait = pickWait();
            end
        end
    endtask

    task automatic compareAll();
        chk("mem_req", 16'(mem_req), 16'(mReq));
        if (mReq) chk("mem_addr", mem_addr, mAddr);
        chk("if_valid", 16'(if_valid), 16'(mValid));
        if (mValid) begin
            chk("if_instr", if_instr, mInstr);
            chk("if_pc", if_pc, mPc);
            chk("if_pc_plus1", if_pc_plus1, mPc + 16'd1);
        end
    endtask

    // Called at a falling edge: check the outputs, drive one cycle of inputs, advance the model.
    task automatic tick(input bit r, input bit s, input bit b, input logic [15:0] t);
        bit ack;
        if (checkOn) compareAll();
        ack           = !r && mReq && (mWait == 0);
        rst           = r;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        mem_ack       = ack;
        mem_rdata     = ack ? memWord(mAddr) : 16'($urandom);
        modelStep(r, s, b, t, ack);
        @(negedge clk);
    endtask

    task automatic chkResetState(input string tag);
        chk({tag, "_mem_req"}, 16'(mem_req), 16'h0000);
        chk({tag, "_mem_addr"}, mem_addr, 16'h0000);
        chk({tag, "_if_instr"}, if_instr, 16'h0800);
        chk({tag, "_if_pc"}, if_pc, 16'h0000);
        chk({tag, "_if_pc_plus1"}, if_pc_plus1, 16'h0001);
        chk({tag, "_if_valid"}, 16'(if_valid), 16'h0000);
    endtask

    initial begin
        bit found;
        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        mem_ack       = 1'b0;
        mem_rdata     = 16'h0000;
        modelReset();

        tick(1, 0, 0, 16'h0);
        checkOn = 1'b1;
        chkResetState("reset");
        tick(1, 0, 0, 16'h0);

        // Zero-wait streaming
        waitMode = 0;
        tick(0, 0, 0, 16'h0);
        chk("first_req", 16'(mem_req), 16'h0001);
        chk("first_addr", mem_addr, 16'h0000);
        chk("no_valid_before_ack", 16'(if_valid), 16'h0000);
        tick(0, 0, 0, 16'h0);
        chk("zw_instr0", if_instr, 16'h1000);
        chk("zw_valid0", 16'(if_valid), 16'h0001);
        chk("zw_addr1", mem_addr, 16'h0001);
        tick(0, 0, 0, 16'h0);
        chk("zw_instr1", if_instr, 16'h1001);
        chk("zw_addr2", mem_addr, 16'h0002);
        tick(0, 0, 0, 16'h0);
        chk("zw_instr2", if_instr, 16'h1002);
        tick(0, 0, 0, 16'h0);
        tick(0, 0, 0, 16'h0);
        chk("pre_stall_addr", mem_addr, 16'h0005);

        // Stall across the ack of address 5
        tick(0, 1, 0, 16'h0);
        chk("hold_req_low", 16'(mem_req), 16'h0000);
        chk("hold_frozen_pc", if_pc, 16'h0004);
        tick(0, 1, 0, 16'h0);
        tick(0, 1, 0, 16'h0);
        chk("hold_frozen_instr", if_instr, 16'h1004);
        chk("hold_frozen_pc2", if_pc, 16'h0004);
        waitMode = 2;
        tick(0, 0, 0, 16'h0);
        chk("unhold_pc", if_pc, 16'h0005);
        chk("unhold_valid", 16'(if_valid), 16'h0001);
        chk("unhold_req", 16'(mem_req), 16'h0001);
        chk("unhold_addr", mem_addr, 16'h0006);

        // Two-wait memory
        for (int i = 0; i < 2; i++) begin
            tick(0, 0, 0, 16'h0);
            chk("w2_addr_stable", mem_addr, 16'h0006);
            chk("w2_bubble", 16'(if_valid), 16'h0000);
        end
        tick(0, 0, 0, 16'h0);
        chk("w2_pc", if_pc, 16'h0006);
        chk("w2_instr", if_instr, 16'h1006);
        chk("w2_next_addr", mem_addr, 16'h0007);
        for (int i = 0; i < 6; i++) tick(0, 0, 0, 16'h0);
        chk("w2_addr9", mem_addr, 16'h0009);

        // Redirect to 0x0040 while the fetch of 9 is waiting
        tick(0, 0, 1, 16'h0040);
        chk("redir_addr_held", mem_addr, 16'h0009);
        tick(0, 0, 0, 16'h0);
        tick(0, 0, 0, 16'h0);
`ifdef IF_DELAY_SLOT_EN
        chk("slot_pc", if_pc, 16'h0009);
        chk("slot_valid", 16'(if_valid), 16'h0001);
`else
        chk("slot_instr", if_instr, 16'h0800);
        chk("slot_valid", 16'(if_valid), 16'h0000);
`endif
        chk("target_addr", mem_addr, 16'h0040);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 16'h0);
        chk("target_pc", if_pc, 16'h0040);
        chk("target_valid", 16'(if_valid), 16'h0001);

        // Wrap from 16'hFFFF
        waitMode = 0;
        tick(0, 0, 1, 16'hFFFE);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(0, 0, 0, 16'h0);
            if (if_valid && if_pc == 16'hFFFF) found = 1'b1;
        end
        chk("wrap_seen", 16'(found), 16'h0001);
        if (found) begin
            chk("wrap_plus1", if_pc_plus1, 16'h0000);
            chk("wrap_next_addr", mem_addr, 16'h0000);
            chk("wrap_instr", if_instr, 16'h0FFF);
            tick(0, 0, 0, 16'h0);
            chk("wrap_pc0", if_pc, 16'h0000);
        end

        // Reset while a fetch waits and decode is stalled
        waitMode = 2;
        for (int i = 0; i < 10 && !(mReq && mWait > 0); i++) tick(0, 0, 0, 16'h0);
        chk("midwait_found", 16'(mReq && mWait > 0), 16'h0001);
        tick(0, 1, 0, 16'h0);
        tick(1, 1, 0, 16'h0);
        chkResetState("midrst");
        tick(0, 0, 0, 16'h0);
        chk("restart_req", 16'(mem_req), 16'h0001);
        chk("restart_addr", mem_addr, 16'h0000);

        // Randomized traffic
        waitMode = -1;
        for (int i = 0; i < 4000; i++) begin
            bit r;
            bit s;
            bit b;
            r = ($urandom_range(0, 299) == 0);
            s = ($urandom_range(0, 3) == 0);
            b = !s && ($urandom_range(0, 7) == 0);
            tick(r, s, b, 16'($urandom));
        end
        compareAll();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
